// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - Mealy serial pattern detector with KMP fallback table
// Optional saturating match counter enabled by defining MATCH_CNT_EN.
module mealy_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       din_valid,
    input  logic                       din,
    output logic                       qout,
    output logic [$clog2(PAT_LEN)-1:0] state
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]           match_cnt
`endif
);

    localparam int SW = $clog2(PAT_LEN);
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

    typedef logic [SW-1:0] state_t;

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("mealy_seq_detector: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("mealy_seq_detector: CNT_W must be at least 1");
    end

    // Entry {s, b} holds the next state after receiving bit b with s bits matched.
    // A completed match falls back to the longest proper border, or to 0 without overlap.
    function automatic logic [31:0][3:0] build_tbl();
        logic [31:0][3:0] t;
        logic [16:0]      str;
        int               best;
        int               lim;
        bit               ok;
        t = '0;
        for (int s = 0; s < PAT_LEN; s++) begin
            for (int b = 0; b < 2; b++) begin
                str = '0;
                for (int i = 0; i <= s; i++) begin
                    if (i < s) str[i] = PATTERN[PAT_LEN-1-i];
                    else       str[i] = b[0];
                end
                lim  = (s + 1 < PAT_LEN) ? s + 1 : PAT_LEN - 1;
                best = 0;
                for (int k = 1; k <= lim; k++) begin
                    ok = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (PATTERN[PAT_LEN-1-j] != str[s+1-k+j]) ok = 1'b0;
                    end
                    if (ok) best = k;
                end
                if (s == PAT_LEN - 1 && b[0] == PATTERN[0] && !OVERLAP) best = 0;
                t[s*2+b] = 4'(best);
            end
        end
        return t;
    endfunction

    localparam logic [31:0][3:0] TBL = build_tbl();

    state_t     state_q;
    state_t     state_d;
    logic [4:0] idx;
    logic [3:0] entry;

    assign qout  = din_valid & ~clr & ~rst & (state_q == LAST) & (din == PATTERN[0]);
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        idx     = {4'(state_q), din};
        entry   = TBL[idx];
        if (clr) begin
            state_d = '0;
        end else if (din_valid) begin
            state_d = SW'(entry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MATCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (clr) begin
            match_cnt <= '0;
        end else if (qout && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb/tb_mealy_seq_detector.sv - directed bench for mealy_seq_detector (overlap and non-overlap)
module tb_mealy_seq_detector;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       din_valid;
    logic       din;
    logic       q_ov;
    logic       q_no;
    logic [1:0] st_ov;
    logic [1:0] st_no;
`ifdef MATCH_CNT_EN
    logic [1:0] cnt_ov;
    logic [1:0] cnt_no;
`endif

    int errors = 0;
    int checks = 0;

    mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_ov (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .din_valid (din_valid),
        .din       (din),
        .qout      (q_ov),
        .state     (st_ov)
`ifdef MATCH_CNT_EN
        ,
        .match_cnt (cnt_ov)
`endif
    );

    mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_no (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .din_valid (din_valid),
        .din       (din),
        .qout      (q_no),
        .state     (st_no)
`ifdef MATCH_CNT_EN
        ,
        .match_cnt (cnt_no)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle at negedge, check the Mealy outputs before the edge and states after.
    task automatic step(input string tag, input logic v, input logic d, input logic c,
                        input logic eq_ov, input logic eq_no, input int es_ov, input int es_no);
        @(negedge clk);
        din_valid = v;
        din       = d;
        clr       = c;
        #1;
        chk({tag, ".q_ov"}, 32'(q_ov), 32'(eq_ov));
        chk({tag, ".q_no"}, 32'(q_no), 32'(eq_no));
        @(posedge clk);
        #1;
        chk({tag, ".st_ov"}, 32'(st_ov), 32'(es_ov));
        chk({tag, ".st_no"}, 32'(st_no), 32'(es_no));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.st_ov", 32'(st_ov), 0);
        chk("reset.q_ov", 32'(q_ov), 0);
`ifdef MATCH_CNT_EN
        chk("reset.cnt_ov", 32'(cnt_ov), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Stream 1,0,1,1,0,1,1: overlap matches at bits 4 and 7, non-overlap only at 4
        step("t1.b1", 1, 1, 0, 0, 0, 1, 1);
        step("t1.b2", 1, 0, 0, 0, 0, 2, 2);
        step("t1.b3", 1, 1, 0, 0, 0, 3, 3);
        step("t1.b4", 1, 1, 0, 1, 1, 1, 0);
        step("t1.b5", 1, 0, 0, 0, 0, 2, 0);
        step("t1.b6", 1, 1, 0, 0, 0, 3, 1);
        step("t1.b7", 1, 1, 0, 1, 0, 1, 1);
`ifdef MATCH_CNT_EN
        chk("t1.cnt_ov", 32'(cnt_ov), 2);
        chk("t1.cnt_no", 32'(cnt_no), 1);
`endif

        // Gap with din_valid=0 must hold state 3 and never flag
        step("t3.clr", 1, 1, 1, 0, 0, 0, 0);
`ifdef MATCH_CNT_EN
        chk("t3.cnt_clr", 32'(cnt_ov), 0);
`endif
        step("t3.b1", 1, 1, 0, 0, 0, 1, 1);
        step("t3.b2", 1, 0, 0, 0, 0, 2, 2);
        step("t3.b3", 1, 1, 0, 0, 0, 3, 3);
        step("t3.g1", 0, 1, 0, 0, 0, 3, 3);
        step("t3.g2", 0, 0, 0, 0, 0, 3, 3);
        step("t3.g3", 0, 1, 0, 0, 0, 3, 3);
        step("t3.b4", 1, 1, 0, 1, 1, 1, 0);

        // Async reset mid-cycle after 1,0,1
        step("t4.pre", 1, 0, 1, 0, 0, 0, 0);
        step("t4.b1", 1, 1, 0, 0, 0, 1, 1);
        step("t4.b2", 1, 0, 0, 0, 0, 2, 2);
        step("t4.b3", 1, 1, 0, 0, 0, 3, 3);
        @(negedge clk);
        din_valid = 1'b1; din = 1'b1; clr = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t4.rst_st", 32'(st_ov), 0);
        chk("t4.rst_q", 32'(q_ov), 0);
`ifdef MATCH_CNT_EN
        chk("t4.rst_cnt", 32'(cnt_ov), 0);
`endif
        #1;
        rst = 1'b0;
        step("t4.r1", 1, 1, 0, 0, 0, 1, 1);
        step("t4.r2", 1, 0, 0, 0, 0, 2, 2);
        step("t4.r3", 1, 1, 0, 0, 0, 3, 3);
        step("t4.r4", 1, 1, 0, 1, 1, 1, 0);

        // clr in the same cycle as the final pattern bit suppresses the match
        step("t5.pre", 1, 0, 1, 0, 0, 0, 0);
        step("t5.b1", 1, 1, 0, 0, 0, 1, 1);
        step("t5.b2", 1, 0, 0, 0, 0, 2, 2);
        step("t5.b3", 1, 1, 0, 0, 0, 3, 3);
        step("t5.b4", 1, 1, 1, 0, 0, 0, 0);

`ifdef MATCH_CNT_EN
        // Six overlapping matches on a 2-bit counter saturate at 3
        step("t6.pre", 1, 0, 1, 0, 0, 0, 0);
        chk("t6.cnt0", 32'(cnt_ov), 0);
        step("t6.b1", 1, 1, 0, 0, 0, 1, 1);
        step("t6.b2", 1, 0, 0, 0, 0, 2, 2);
        step("t6.b3", 1, 1, 0, 0, 0, 3, 3);
        step("t6.b4", 1, 1, 0, 1, 1, 1, 0);
        chk("t6.cnt_m1", 32'(cnt_ov), 1);
        for (int m = 2; m <= 6; m++) begin
            step("t6.x0", 1, 0, 0, 0, 0, 2, (m % 2 == 0) ? 0 : 2);
            step("t6.x1", 1, 1, 0, 0, 0, 3, (m % 2 == 0) ? 1 : 3);
            step("t6.x2", 1, 1, 0, 1, (m % 2 == 1), 1, (m % 2 == 0) ? 1 : 0);
            chk("t6.cnt", 32'(cnt_ov), (m < 3) ? m : 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
